uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel receive half of the on-board UART: recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous `serial_in` line and presents each byte on a ready/valid output held in a one-entry buffer. It sits between the FPGA RX pin and the CPU memory-mapped I/O block. Each sample is taken at the centre of its bit. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLOCK_FREQ`, 125_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bits/s
- Derived: `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer divide), `SAMPLE_TIME = SYMBOL_EDGE_TIME / 2`, counter width `$clog2(SYMBOL_EDGE_TIME)`
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `serial_in`  in  1  asynchronous RX line; idle high
- `data_out`  out  8  received byte; stable while `data_out_valid` is high
- `data_out_valid`  out  1  `data_out` holds an unconsumed byte
- `data_out_ready`  in  1  consumer accepts the byte this cycle
- `framing_error`  out  1  one-cycle pulse: a stop bit was sampled low
- `overrun`  out  1  one-cycle pulse: a good frame was dropped because the buffer was full

## Operation
- **Synchronizer.** `serial_in` passes through two flops, both reset to 1. All logic uses the second flop, `rx`.
- **Counters.**
  - Clock counter: increments every cycle outside IDLE and clears on every state change and on every sample.
  - Bit counter: counts data bits 0..7.
- **States.**
  - IDLE: on `rx == 0` → START, counter cleared.
  - START: at counter `SAMPLE_TIME-1`, sample `rx`. If 1, treat as a glitch → IDLE with no pulse. If 0 → DATA, bit counter = 0.
  - DATA: at counter `SYMBOL_EDGE_TIME-1`, sample `rx` into `shift[bit]` (LSB first). After bit 7 → STOP.
  - STOP: at counter `SYMBOL_EDGE_TIME-1`, sample `rx`, then → IDLE in all cases.
    - Sample 0: pulse `framing_error` and discard the byte.
    - Sample 1 with buffer empty, or being drained this same cycle: load `data_out` and set valid.
    - Sample 1 with buffer full and `data_out_ready` low: pulse `overrun`, discard the new byte, keep the old byte.
- Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught with no gap.
- **Output buffer.**
  - `data_out_valid & data_out_ready` clears valid the next cycle.
  - If a load coincides with that handshake, the load wins: valid stays 1 and `data_out` takes the new byte.
  - `data_out` is unchanged while valid is high without a handshake.
- **Reset.** Forces IDLE, both counters to 0, `data_out = 8'h00`, `data_out_valid = 0`, `framing_error = 0`, `overrun = 0`, both synchronizer flops to 1. Reset applied mid-frame aborts the frame with no pulses. After reset, the receiver waits for `rx` to go low again.
- **Reset value of shift register.** Don't care; not observable.

## Timing
- T0 is the cycle in which IDLE first sees `rx == 0`. This is 2–3 cycles after the `serial_in` falling edge.
- Start sample: T0 + `SAMPLE_TIME`.
- Data bit k sample: T0 + `SAMPLE_TIME` + (k+1)·`SYMBOL_EDGE_TIME`.
- Stop sample: T0 + `SAMPLE_TIME` + 9·`SYMBOL_EDGE_TIME`.
- `data_out_valid` rises, or an error pulse fires, on the cycle after the stop sample. Each pulse is exactly 1 cycle wide.
- Throughput: one byte per 10 bit times. `data_out_ready` has no combinational path to any output.
- Tolerates ±(`SAMPLE_TIME`−2) cycles of accumulated baud mismatch across a frame.

## Test plan
Parameters for all tests: `SYMBOL_EDGE_TIME = 1085`, `SAMPLE_TIME = 542`.

- **Single byte.** Drive `8'hA5` frame with `data_out_ready` = 1 → `data_out = 8'hA5` and valid high for exactly 1 cycle at T0 + 542 + 9·1085 + 1. No error pulses.
- **Back-to-back.** Send `8'h00`, `8'hFF`, `8'h5A` with no idle gap, ready held at 1 → three valid strobes with those bytes, 10850 cycles apart.
- **Backpressure / overrun.** Send `8'h11`, hold ready at 0, then send `8'h22` → valid stays high with `8'h11` and `overrun` pulses once. Raise ready → valid drops the next cycle; `8'h22` never appears.
- **Simultaneous load and drain.** Assert ready exactly in the load cycle of a second byte `8'h33` while `8'h11` is pending → valid stays 1 and `data_out = 8'h33` the next cycle. No overrun.
- **Framing error and glitch.**
  - Frame `8'h3C` with stop bit driven 0 → `framing_error` pulses and valid stays 0.
  - A 200-cycle low glitch on idle line → no valid and no pulses; a following good `8'h7E` is received.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 → all outputs 0 the next cycle, no pulses. The next full frame `8'hC3` is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: two-flop synchronizer, centre-sampling bit FSM and
// a one-entry ready/valid output buffer with framing-error and overrun pulses.
module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic             sync_q, rx_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             start_sample;
  logic             bit_sample;
  logic             stop_sample;

  assign start_sample = (state_q == START) && (cnt_q == SAMPLE_LAST);
  assign bit_sample   = ((state_q == DATA) || (state_q == STOP)) && (cnt_q == SYMBOL_LAST);
  assign stop_sample  = (state_q == STOP) && bit_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= serial_in;
      rx_q      <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_q) state_d = START;
      START:   if (start_sample) state_d = rx_q ? IDLE : DATA;
      DATA:    if (bit_sample && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (bit_sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q && !data_out_ready;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if ((state_q == IDLE) || (state_d != state_q) || start_sample || bit_sample) begin
      cnt_d = '0;
    end

    if (start_sample) begin
      bit_idx_d = '0;
    end

    if ((state_q == DATA) && bit_sample) begin
      shift_d[bit_idx_q] = rx_q;
      bit_idx_d          = bit_idx_q + 3'd1;
    end

    // A load in the same cycle as a drain handshake overrides the clear.
    if (stop_sample) begin
      if (!rx_q) begin
        ferr_d = 1'b1;
      end else if (!valid_q || data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = ferr_q;
  assign overrun        = ovr_q;

endmodule
